// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder
// Description : Responder end of the data-side sram-like port. EXE issues
//               req/addr handshakes, MEM consumes data_ok/rdata. Up to
//               QDEPTH requests are held in an in-order circular queue. Each
//               entry retires LATENCY cycles after acceptance with a
//               one-cycle data_ok. Reads return the full aligned word, and
//               writes update memory bytes under wstrb at retire.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W     word-index bits; memory is 2**ADDR_W x 32b (ADDR_W <= 29)
//   LATENCY    cycles from acceptance edge to data_ok (1..7)
//   QDEPTH     max outstanding requests (1..4)
//   LFSR_SEED  nonzero seed for the random-delay LFSR
// Ports
//   clk                in   1   clock, all state updates on posedge
//   reset              in   1   synchronous, active-high
//   data_sram_req      in   1   request valid
//   data_sram_wr       in   1   1 = write, 0 = read
//   data_sram_wstrb    in   4   byte enables for writes
//   data_sram_addr     in   32  byte address, index = addr[ADDR_W+1:2]
//   data_sram_wdata    in   32  write data, pre-aligned by the requester
//   data_sram_addr_ok  out  1   request accepted when req && addr_ok
//   data_sram_data_ok  out  1   head request retires this cycle
//   data_sram_rdata    out  32  read word when data_ok on a read, else 0
// Build options
//   DSRAM_RAND_DELAY_EN  when defined, an 8-bit LFSR randomly withholds
//                        addr_ok (lfsr[1]) and data_ok (lfsr[0]) to
//                        stress requester stall handling.
// ============================================================================
module data_sram_responder #(
  parameter int         ADDR_W    = 12,
  parameter int         LATENCY   = 1,
  parameter int         QDEPTH    = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int                PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int                OCC_W    = 3;
  localparam logic [2:0]        LAT_C    = 3'(LATENCY);
  localparam logic [OCC_W-1:0]  QD_C     = OCC_W'(QDEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(QDEPTH - 1);
  localparam int                MEM_WORDS = 1 << ADDR_W;

  // Elaboration-time legality checks on the configuration.
  if (LATENCY < 1 || LATENCY > 7 || QDEPTH < 1 || QDEPTH > 4 ||
      ADDR_W < 1 || ADDR_W > 29 || LFSR_SEED == 8'h00) begin : g_param_check
    $error("data_sram_responder: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0]       mem [MEM_WORDS];

  logic [QDEPTH-1:0] r_q_valid;
  logic [QDEPTH-1:0] r_q_wr;
  logic [3:0]        r_q_wstrb [QDEPTH];
  logic [ADDR_W-1:0] r_q_idx   [QDEPTH];
  logic [31:0]       r_q_wdata [QDEPTH];
  logic [2:0]        r_q_cnt   [QDEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [OCC_W-1:0]  r_count;

  logic              w_space;
  logic              w_head_ready;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Byte-offset bits and bits above the index are deliberately ignored
  // (addresses wrap modulo the memory size).
  assign w_unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
  assign w_idx         = data_sram_addr[ADDR_W+1:2];

  assign w_space      = (r_count < QD_C);
  assign w_head_ready = r_q_valid[r_head] && (r_q_cnt[r_head] == LAT_C);

  // --------------------------------------------------------------------------
  // Handshake generation (optionally throttled by the LFSR)
  // --------------------------------------------------------------------------
`ifdef DSRAM_RAND_DELAY_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR for x^8 + x^6 + x^5 + x^4 + 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  // A ready head that is withheld keeps waiting; its cnt stays saturated.
  assign data_sram_addr_ok = !reset && w_space && r_lfsr[1];
  assign data_sram_data_ok = !reset && w_head_ready && r_lfsr[0];
`else
  // addr_ok looks only at occupancy, never at data_ok or req, so the
  // requester sees no combinational path through this block.
  assign data_sram_addr_ok = !reset && w_space;
  assign data_sram_data_ok = !reset && w_head_ready;
`endif

  assign w_push = data_sram_req && data_sram_addr_ok;
  assign w_pop  = data_sram_data_ok;

  // Memory is only touched at retire, so a read queued behind a write to
  // the same word already sees the written data here.
  assign data_sram_rdata = (w_pop && !r_q_wr[r_head]) ? mem[r_q_idx[r_head]] : 32'h0;

  // --------------------------------------------------------------------------
  // Queue control: valid bits, pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_valid <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
    end else begin
      // Push and pop never hit the same slot: a push requires a free slot,
      // and a pop requires the head to be valid.
      if (w_pop) begin
        r_q_valid[r_head] <= 1'b0;
        r_head            <= ptr_inc(r_head);
      end
      if (w_push) begin
        r_q_valid[r_tail] <= 1'b1;
        r_tail            <= ptr_inc(r_tail);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Queue payload and age counters (qualified by r_q_valid, no reset needed)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (r_q_valid[i] && (r_q_cnt[i] < LAT_C)) begin
        r_q_cnt[i] <= r_q_cnt[i] + 3'd1;
      end
    end
    if (w_push) begin
      r_q_wr[r_tail]    <= data_sram_wr;
      r_q_wstrb[r_tail] <= data_sram_wstrb;
      r_q_idx[r_tail]   <= w_idx;
      r_q_wdata[r_tail] <= data_sram_wdata;
      r_q_cnt[r_tail]   <= 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Memory array: byte-masked write at retire of a write entry
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_pop && r_q_wr[r_head]) begin
      for (int b = 0; b < 4; b++) begin
        if (r_q_wstrb[r_head][b]) begin
          mem[r_q_idx[r_head]][8*b +: 8] <= r_q_wdata[r_head][8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
